// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: RV32I funct3
// width/sign encodings and the access-sequencing FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory handshake bus between the LSU (master) and the memory (slave).
interface mem_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_align.sv
// Pure combinational alignment helper: legality of the incoming access,
// byte enables and lane-replicated store data for the request, and lane
// extraction plus sign/zero extension of the returned read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        rd,
  input  logic        wr,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // Legality: one strobe only, a funct3 valid for that direction, natural alignment
  always_comb begin
    legal = 1'b0;
    if (rd && !wr) begin
      unique case (funct3)
        F3_B, F3_BU: legal = 1'b1;
        F3_H, F3_HU: legal = ~addr_lo[0];
        F3_W:        legal = (addr_lo == 2'b00);
        default:     legal = 1'b0;
      endcase
    end else if (wr && !rd) begin
      unique case (funct3)
        F3_B:    legal = 1'b1;
        F3_H:    legal = ~addr_lo[0];
        F3_W:    legal = (addr_lo == 2'b00);
        default: legal = 1'b0;
      endcase
    end
  end

  // Byte enables and store-data replication so every lane carries the datum
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  // Load path: move the addressed lane down to bit 0, then extend by width/sign
  always_comb begin
    shifted   = rdata >> {ld_addr_lo, 3'b000};
    rdata_ext = 32'h0;
    unique case (ld_funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
      F3_W:    rdata_ext = rdata;
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: accepts an access from EX/MEM, issues exactly
// one request on the data-memory bus, stalls the pipeline until the memory
// acks (or the wait times out), then presents the extended load result for
// a single DONE cycle.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread_MEM,
  input  logic        memwrite_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [31:0] alu_MEM,
  input  logic [31:0] writedata_MEM,
  output logic [31:0] readdata_MEM,
  output logic        lsu_stall,
  output logic        err_misalign,
  output logic        err_timeout,
  mem_lsu_if.master   mem
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  lsu_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        load_q, load_d;

  logic        legal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] rdata_ext;

  // The load lane is extracted using the access attributes captured at issue,
  // so the result does not depend on what the pipeline presents during WAIT.
  lsu_align u_align (
    .rd         (memread_MEM),
    .wr         (memwrite_MEM),
    .funct3     (funct3_MEM),
    .addr_lo    (alu_MEM[1:0]),
    .wdata      (writedata_MEM),
    .legal      (legal),
    .be         (be_new),
    .wdata_rep  (wdata_new),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .rdata      (mem.mem_rdata),
    .rdata_ext  (rdata_ext)
  );

  // Next-state, request register updates and combinational stall/error outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    result_d     = result_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    load_d       = load_q;
    lsu_stall    = 1'b0;
    err_misalign = 1'b0;
    err_timeout  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (memread_MEM || memwrite_MEM) begin
          if (legal) begin
            lsu_stall = 1'b1;
            state_d   = WAIT;
            cnt_d     = 16'h0;
            req_d     = 1'b1;
            we_d      = memwrite_MEM;
            addr_d    = {alu_MEM[31:2], 2'b00};
            be_d      = be_new;
            wdata_d   = wdata_new;
            addr_lo_d = alu_MEM[1:0];
            funct3_d  = funct3_MEM;
            load_d    = memread_MEM;
            result_d  = 32'h0;
          end else begin
            err_misalign = 1'b1;
          end
        end
      end
      WAIT: begin
        lsu_stall = 1'b1;
        if (mem.mem_ack) begin
          result_d = load_q ? rdata_ext : 32'h0;
          req_d    = 1'b0;
          state_d  = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_timeout = 1'b1;
          result_d    = 32'h0;
          req_d       = 1'b0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State, counter and bus registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 16'h0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      be_q      <= 4'h0;
      wdata_q   <= 32'h0;
      result_q  <= 32'h0;
      addr_lo_q <= 2'b00;
      funct3_q  <= 3'b000;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      result_q  <= result_d;
      addr_lo_q <= addr_lo_d;
      funct3_q  <= funct3_d;
      load_q    <= load_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign readdata_MEM  = (state_q == DONE) ? result_q : 32'h0;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu with hand-computed expectations.
module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic        memread_MEM;
  logic        memwrite_MEM;
  logic [2:0]  funct3_MEM;
  logic [31:0] alu_MEM;
  logic [31:0] writedata_MEM;
  logic [31:0] readdata_MEM;
  logic        lsu_stall;
  logic        err_misalign;
  logic        err_timeout;

  int tests_run = 0;
  int tests_failed = 0;

  mem_lsu_if mem_bus ();

  mem_lsu #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .memread_MEM   (memread_MEM),
    .memwrite_MEM  (memwrite_MEM),
    .funct3_MEM    (funct3_MEM),
    .alu_MEM       (alu_MEM),
    .writedata_MEM (writedata_MEM),
    .readdata_MEM  (readdata_MEM),
    .lsu_stall     (lsu_stall),
    .err_misalign  (err_misalign),
    .err_timeout   (err_timeout),
    .mem           (mem_bus)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Runs one instruction through the LSU from IDLE until the first cycle with
  // stall low (DONE, or the same IDLE cycle for an illegal access), acting as
  // the memory: ack is given on WAIT cycle number ack_after (-1 = never).
  task automatic applyStimulus(
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    input  int          ack_after,
    output int          stall_cycles,
    output int          req_rises,
    output logic [31:0] result,
    output logic        saw_misalign,
    output logic        saw_timeout,
    output logic [3:0]  be,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    output logic        unstable
  );
    int   wait_idx;
    logic prev_req;
    logic got_req;
    logic finished;
    memread_MEM   = rd;
    memwrite_MEM  = wr;
    funct3_MEM    = f3;
    alu_MEM       = addr;
    writedata_MEM = wd;
    stall_cycles  = 0;
    req_rises     = 0;
    result        = 32'hx;
    saw_misalign  = 1'b0;
    saw_timeout   = 1'b0;
    be            = 4'h0;
    maddr         = 32'h0;
    mwdata        = 32'h0;
    unstable      = 1'b0;
    wait_idx      = 0;
    prev_req      = 1'b0;
    got_req       = 1'b0;
    finished      = 1'b0;
    for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
      if (mem_bus.mem_req) begin
        mem_bus.mem_ack   = (wait_idx == ack_after);
        mem_bus.mem_rdata = rdata;
        wait_idx++;
      end else begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
      end
      @(negedge clk);
      if (mem_bus.mem_req && !prev_req) req_rises++;
      prev_req = mem_bus.mem_req;
      if (mem_bus.mem_req) begin
        if (!got_req) begin
          be     = mem_bus.mem_be;
          maddr  = mem_bus.mem_addr;
          mwdata = mem_bus.mem_wdata;
          got_req = 1'b1;
        end else if (mem_bus.mem_be !== be || mem_bus.mem_addr !== maddr ||
                     mem_bus.mem_wdata !== mwdata) begin
          unstable = 1'b1;
        end
      end
      if (err_misalign) saw_misalign = 1'b1;
      if (err_timeout)  saw_timeout  = 1'b1;
      if (lsu_stall) begin
        stall_cycles++;
      end else begin
        result   = readdata_MEM;
        finished = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!finished) checkOutput("cycle_bound", 32'd0, 32'd1);
    memread_MEM       = 1'b0;
    memwrite_MEM      = 1'b0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;
  endtask

  int          sc, rr;
  logic [31:0] res, ma, mw;
  logic        mis, tmo, uns;
  logic [3:0]  mbe;

  initial begin
    rst               = 1'b1;
    memread_MEM       = 1'b0;
    memwrite_MEM      = 1'b0;
    funct3_MEM        = 3'b000;
    alu_MEM           = 32'h0;
    writedata_MEM     = 32'h0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req",    {31'h0, mem_bus.mem_req}, 32'h0);
    checkOutput("rst_we",     {31'h0, mem_bus.mem_we},  32'h0);
    checkOutput("rst_addr",   mem_bus.mem_addr,         32'h0);
    checkOutput("rst_be",     {28'h0, mem_bus.mem_be},  32'h0);
    checkOutput("rst_wdata",  mem_bus.mem_wdata,        32'h0);
    checkOutput("rst_stall",  {31'h0, lsu_stall},       32'h0);
    checkOutput("rst_rdata",  readdata_MEM,             32'h0);
    checkOutput("rst_errs",   {30'h0, err_misalign, err_timeout}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ack arriving while idle is ignored
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput("idle_ack_stall", {31'h0, lsu_stall}, 32'h0);
    @(posedge clk);
    #1;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("idle_ack_rdata", readdata_MEM, 32'h0);
    checkOutput("idle_ack_req", {31'h0, mem_bus.mem_req}, 32'h0);
    @(posedge clk);
    #1;

    // SW 0x100, ack on second WAIT cycle
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("sw_be",     {28'h0, mbe}, 32'hF);
    checkOutput("sw_addr",   ma,  32'h100);
    checkOutput("sw_wdata",  mw,  32'hDEADBEEF);
    checkOutput("sw_stall",  sc,  32'd3);
    checkOutput("sw_reqs",   rr,  32'd1);
    checkOutput("sw_result", res, 32'h0);
    checkOutput("sw_stable", {31'h0, uns}, 32'h0);

    // LB / LBU from lane 3, same-cycle ack
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("lb_result", res, 32'hFFFF_FF80);
    checkOutput("lb_stall",  sc,  32'd2);
    checkOutput("lb_be",     {28'h0, mbe}, 32'h8);
    checkOutput("lb_addr",   ma,  32'h100);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("lbu_result", res, 32'h0000_0080);

    // LB lane 1 positive, LH/LHU upper half
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h1234_5678, 0, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("lb1_result", res, 32'h0000_0056);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 0, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("lh_result", res, 32'hFFFF_8001);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 2, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("lhu_result", res, 32'h0000_8001);
    checkOutput("lhu_stall",  sc,  32'd4);

    // SH 0x202 and SB 0x007 lane replication
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 0, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("sh_be",    {28'h0, mbe}, 32'hC);
    checkOutput("sh_wdata", mw, 32'hABCD_ABCD);
    checkOutput("sh_addr",  ma, 32'h200);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h007, 32'h0000_00A5, 32'h0, 0, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("sb_be",    {28'h0, mbe}, 32'h8);
    checkOutput("sb_wdata", mw, 32'hA5A5_A5A5);

    // Illegal accesses: misaligned LW, store with load-only funct3, both strobes
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("lw_mis_err",    {31'h0, mis}, 32'h1);
    checkOutput("lw_mis_reqs",   rr,  32'd0);
    checkOutput("lw_mis_stall",  sc,  32'd0);
    checkOutput("lw_mis_result", res, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("st_f3_err",  {31'h0, mis}, 32'h1);
    checkOutput("st_f3_reqs", rr, 32'd0);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 0, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("both_err",  {31'h0, mis}, 32'h1);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 0, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("lh_mis_err", {31'h0, mis}, 32'h1);

    // Timeout: no ack, TIMEOUT=4 WAIT cycles then DONE with zero result
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h5555_5555, -1, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("to_err",    {31'h0, tmo}, 32'h1);
    checkOutput("to_stall",  sc,  32'd5);
    checkOutput("to_result", res, 32'h0);
    checkOutput("to_req_dropped", {31'h0, mem_bus.mem_req}, 32'h0);

    // Ack on the last allowed WAIT cycle wins over the timeout
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h010, 32'h0, 32'hCAFE_F00D, 3, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("late_ack_err",    {31'h0, tmo}, 32'h0);
    checkOutput("late_ack_result", res, 32'hCAFE_F00D);
    checkOutput("late_ack_stall",  sc,  32'd5);

    // Reset during WAIT with a pending ack
    memread_MEM = 1'b1;
    funct3_MEM  = 3'b010;
    alu_MEM     = 32'h20;
    @(posedge clk);
    #1;
    checkOutput("rw_req_up", {31'h0, mem_bus.mem_req}, 32'h1);
    rst               = 1'b1;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'h1111_2222;
    @(posedge clk);
    #1;
    rst             = 1'b0;
    memread_MEM     = 1'b0;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("rw_req",   {31'h0, mem_bus.mem_req}, 32'h0);
    checkOutput("rw_stall", {31'h0, lsu_stall}, 32'h0);
    checkOutput("rw_rdata", readdata_MEM, 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h040, 32'h0, 32'h0BAD_CAFE, 1, sc, rr, res, mis, tmo, mbe, ma, mw, uns);
    checkOutput("rw_lw_result", res, 32'h0BAD_CAFE);
    checkOutput("rw_lw_reqs",   rr,  32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
